// File: rtl/sbox_pipe_unit.sv
// sbox_pipe_unit: 3-stage multi-lane AES SubBytes/InvSubBytes engine; define SBOX_STATS_EN to add the beat_cnt completion counter
module sbox_pipe_unit #(
  parameter int LANES = 4,
  localparam int DW = 8 * LANES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_mode,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_mode,
  output logic [DW-1:0] out_data
`ifdef SBOX_STATS_EN
  ,
  output logic [15:0]   beat_cnt
`endif
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ t : p;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] p, r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction
  function automatic logic [7:0] fwd_aff(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [7:0] inv_aff(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  endfunction
  logic          v1, v2, v3, m1, m2, m3;
  logic [DW-1:0] d1, d2, d3, t1, t2, t3;
  logic          adv;
  assign adv       = !v3 | out_ready;
  assign in_ready  = adv;
  assign out_valid = v3;
  assign out_mode  = m3;
  assign out_data  = d3;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign t1[8*g+:8] = in_mode ? inv_aff(in_data[8*g+:8]) : in_data[8*g+:8];
    assign t2[8*g+:8] = ginv(d1[8*g+:8]);
    assign t3[8*g+:8] = m2 ? d2[8*g+:8] : fwd_aff(d2[8*g+:8]);
  end
  // whole pipe shifts together on adv; flush drops every beat in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {v1, v2, v3, m1, m2, m3} <= '0;
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
    end else if (flush) begin
      {v1, v2, v3} <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      m1 <= in_mode;
      d1 <= t1;
      v2 <= v1;
      m2 <= m1;
      d2 <= t2;
      v3 <= v2;
      m3 <= m2;
      d3 <= t3;
    end
`ifdef SBOX_STATS_EN
  // saturating count of beats taken downstream; flush wins over a same-cycle completion
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) beat_cnt <= '0;
    else if (flush) beat_cnt <= '0;
    else if (out_valid & out_ready & ~&beat_cnt) beat_cnt <= beat_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_sbox_pipe_unit.sv
// tb_sbox_pipe_unit: directed checks of the S-box pipe with known AES S-box vectors
module tb_sbox_pipe_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_mode = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_mode;
  logic [31:0] out_data;
`ifdef SBOX_STATS_EN
  logic [15:0] beat_cnt;
`endif
  int checks = 0;
  int errors = 0;
  logic [31:0] fw [64];
  logic [31:0] vin  [8];
  logic [31:0] vexp [8];
  logic        vmod [8];

  sbox_pipe_unit dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode), .out_data(out_data)
`ifdef SBOX_STATS_EN
    , .beat_cnt(beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    vin  = '{32'hFF530100, 32'h16ED7C63, 32'h10203040, 32'hCAB70409,
             32'h80C0AA55, 32'hCDBAACFC, 32'h00000000, 32'h63636363};
    vexp = '{32'h16ED7C63, 32'hFF530100, 32'hCAB70409, 32'h10203040,
             32'hCDBAACFC, 32'h80C0AA55, 32'h63636363, 32'h00000000};
    vmod = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    #7;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_mode", 32'(out_mode), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    // single forward beat, latency 3
    in_valid = 1'b1; in_mode = 1'b0; in_data = 32'hFF530100;
    tick();
    in_valid = 1'b0;
    tick();
    chk("lat_not_early", 32'(out_valid), 32'd0);
    tick();
    chk("fwd_valid", 32'(out_valid), 32'd1);
    chk("fwd_data", out_data, 32'h16ED7C63);
    chk("fwd_mode", 32'(out_mode), 32'd0);
    tick();
    // single inverse beat
    in_valid = 1'b1; in_mode = 1'b1; in_data = 32'h16ED7C63;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("inv_valid", 32'(out_valid), 32'd1);
    chk("inv_data", out_data, 32'hFF530100);
    chk("inv_mode", 32'(out_mode), 32'd1);
    tick();
    // 8 back-to-back beats, alternating mode
    for (int c = 0; c < 11; c++) begin
      in_valid = c < 8;
      in_mode  = c < 8 ? vmod[c] : 1'b0;
      in_data  = c < 8 ? vin[c] : 32'd0;
      tick();
      if (c >= 2 && c <= 9) begin
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_data", out_data, vexp[c-2]);
        chk("b2b_mode", 32'(out_mode), 32'(vmod[c-2]));
      end else if (c == 10) chk("b2b_end", 32'(out_valid), 32'd0);
    end
    // stall with 3 beats in flight
    out_ready = 1'b0;
    in_mode = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_data  = vin[2*c];
      tick();
    end
    in_data = 32'h11223344;
    for (int c = 0; c < 3; c++) begin
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", out_data, 32'h16ED7C63);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rel_a", out_data, 32'h16ED7C63);
    tick();
    chk("rel_b_valid", 32'(out_valid), 32'd1);
    chk("rel_b", out_data, 32'hCAB70409);
    tick();
    chk("rel_c_valid", 32'(out_valid), 32'd1);
    chk("rel_c", out_data, 32'hCDBAACFC);
    tick();
    chk("rel_done", 32'(out_valid), 32'd0);
    // flush with full pipe and a beat offered
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_data  = vin[2*c];
      tick();
    end
    flush = 1'b1;
    in_data = 32'h11223344;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("flush_quiet", 32'(out_valid), 32'd0);
    end
    // asynchronous reset mid-stream
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_mode  = 1'b1;
      in_data  = vin[2*c+1];
      tick();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", out_data, 32'd0);
    chk("arst_mode", 32'(out_mode), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("arst_quiet", 32'(out_valid), 32'd0);
    end
    // all 256 bytes forward, then back through the inverse
    for (int c = 0; c < 66; c++) begin
      in_valid = c < 64;
      in_mode  = 1'b0;
      in_data  = {8'(4*c+3), 8'(4*c+2), 8'(4*c+1), 8'(4*c)};
      tick();
      if (c >= 2) begin
        chk("rt_fwd_valid", 32'(out_valid), 32'd1);
        fw[c-2] = out_data;
      end
    end
    chk("rt_fwd_first", fw[0], 32'h7B777C63);
    for (int c = 0; c < 66; c++) begin
      in_valid = c < 64;
      in_mode  = 1'b1;
      in_data  = c < 64 ? fw[c] : 32'd0;
      tick();
      if (c >= 2) chk("rt_inv", out_data, {8'(4*c-5), 8'(4*c-6), 8'(4*c-7), 8'(4*c-8)});
    end
    in_valid = 1'b0;
    tick();
    tick();
`ifdef SBOX_STATS_EN
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    chk("cnt_rst", 32'(beat_cnt), 32'd0);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_mode  = 1'b0;
      in_data  = vin[c];
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    chk("cnt_five", 32'(beat_cnt), 32'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("cnt_flush", 32'(beat_cnt), 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
